// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

   localparam int NDIG  = 8;
   localparam int NSEG  = 7;
   localparam int IDX_W = $clog2(NDIG);

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   // Segment patterns {a,b,c,d,e,f,g}, active-high, indexed by nibble value
   localparam logic [NSEG-1:0] HEX_SEG [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to seven-segment decoder.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0]      nib,
   output logic [NSEG-1:0] seg
);

   // Table lookup of the segment pattern for one hex digit
   always_comb begin
      seg = HEX_SEG[nib];
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Optional build macro SEG7_LZB_EN: leading-zero blanking of unused upper digits.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_BLANK | all digits off for BLANK_CYC cycles (anti-ghosting gap)
// S_DRIVE | digit idx lit for DWELL_CYC cycles
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DWELL_CYC = 10000,
   parameter int BLANK_CYC = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            en,
   input  logic            wr_en,
   input  logic [31:0]     wr_data,
   output logic [NDIG-1:0] num_csn,
   output logic [NSEG-1:0] num_a_g,
   output logic            frame_done
);

   localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   // With no blanking a BLANK state is only ever seen after reset/disable; leave it at once
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
   localparam state_t AFTER_DRIVE = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;

   state_t            state, state_nx;
   logic [IDX_W-1:0]  idx, idx_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [31:0]       shown, shown_nx;
   logic [31:0]       pend_data, pend_nx;
   logic              pending, pending_nx;
   logic              done_nx;
   logic [NDIG-1:0]   csn_nx;
   logic [NSEG-1:0]   a_g_nx;
   logic [3:0]        nib;
   logic [NSEG-1:0]   seg;
   logic              lit;

   // Decode the nibble belonging to the digit that will be shown next cycle
   assign nib = shown_nx[{idx_nx, 2'b00} +: 4];

   seg7_hex_decode u_dec (
      .nib (nib),
      .seg (seg)
   );

   // State, counter, display data and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_BLANK;
         idx        <= '0;
         cnt        <= '0;
         shown      <= '0;
         pend_data  <= '0;
         pending    <= 1'b0;
         num_csn    <= '1;
         num_a_g    <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         shown      <= shown_nx;
         pend_data  <= pend_nx;
         pending    <= pending_nx;
         num_csn    <= csn_nx;
         num_a_g    <= a_g_nx;
         frame_done <= done_nx;
      end
   end

   // Next-state, frame-boundary commit and next-cycle output values
   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      cnt_nx     = cnt + CNT_W'(1);
      shown_nx   = shown;
      pend_nx    = pend_data;
      pending_nx = pending;
      done_nx    = 1'b0;

      if (wr_en) begin
         pend_nx    = wr_data;
         pending_nx = 1'b1;
      end

      if (!en) begin
         state_nx = S_BLANK;
         idx_nx   = '0;
         cnt_nx   = '0;
      end else begin
         case (state)
            S_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_nx = S_DRIVE;
                  cnt_nx   = '0;
               end
            end
            S_DRIVE: begin
               if (cnt == DWELL_LAST) begin
                  state_nx = AFTER_DRIVE;
                  cnt_nx   = '0;
                  idx_nx   = idx + IDX_W'(1);
                  if (idx == IDX_W'(NDIG - 1)) begin
                     done_nx    = 1'b1;
                     pending_nx = 1'b0;
                     // A write landing exactly on the boundary goes straight to the next frame
                     if (wr_en)
                        shown_nx = wr_data;
                     else if (pending)
                        shown_nx = pend_data;
                  end
               end
            end
            default: state_nx = S_BLANK;
         endcase
      end

`ifdef SEG7_LZB_EN
      lit = (idx_nx == '0) || ((shown_nx >> {idx_nx, 2'b00}) != '0);
`else
      lit = 1'b1;
`endif

      if ((state_nx == S_DRIVE) && lit) begin
         csn_nx = ~(NDIG'(1) << idx_nx);
         a_g_nx = seg;
      end else begin
         csn_nx = '1;
         a_g_nx = '0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (DWELL_CYC=4, BLANK_CYC=2).
// The monitor collapses the output stream into runs of constant {csn,a_g}
// and checks each finished run (pattern, length, frame_done count) against
// expectations queued by the stimulus process.
module tb_seg7_scan_ctrl;

   typedef struct packed {
      logic [7:0] csn;
      logic [6:0] ag;
      int         len;
      int         done;
   } run_t;

   localparam logic [6:0] TAB [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [7:0]  num_csn;
   logic [6:0]  num_a_g;
   logic        frame_done;

   int   total = 0;
   int   bad = 0;
   int   cur = 0;
   bit   mon_on = 1'b0;
   run_t q[$];
   run_t pend;
   bit   pend_v = 1'b0;

   seg7_scan_ctrl #(.DWELL_CYC(4), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .en         (en),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .num_csn    (num_csn),
      .num_a_g    (num_a_g),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // ---------------- expectation builder ----------------
   task automatic add_run(input logic [7:0] c, input logic [6:0] a, input int len, input int done);
      if (pend_v && pend.csn == c && pend.ag == a) begin
         pend.len  = pend.len + len;
         pend.done = pend.done + done;
      end else begin
         if (pend_v) q.push_back(pend);
         pend.csn  = c;
         pend.ag   = a;
         pend.len  = len;
         pend.done = done;
         pend_v    = 1'b1;
      end
   endtask

   task automatic flush_runs();
      if (pend_v) q.push_back(pend);
      pend_v = 1'b0;
   endtask

   task automatic add_blank(input int len, input int done);
      add_run(8'hFF, 7'h00, len, done);
   endtask

   task automatic add_slot(input logic [31:0] v, input int d, input int len, input int done);
      logic [31:0] sh;
      logic [3:0]  n;
      logic [7:0]  c;
      bit          on;
      sh = v >> (4 * d);
      n  = sh[3:0];
`ifdef SEG7_LZB_EN
      on = (d == 0) || (sh != 0);
`else
      on = 1'b1;
`endif
      c = 8'hFF;
      c[d] = 1'b0;
      if (on) add_run(c, TAB[n], len, done);
      else    add_run(8'hFF, 7'h00, len, done);
   endtask

   task automatic add_frame(input logic [31:0] v, input int first_done);
      for (int d = 0; d < 8; d++) begin
         add_blank(2, (d == 0) ? first_done : 0);
         add_slot(v, d, 4, 0);
      end
   endtask

   // ---------------- monitor ----------------
   logic [14:0] run_key;
   int          run_len;
   int          run_done;
   bit          run_act = 1'b0;

   task automatic check_run();
      run_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL run_unexpected: got csn=%h a_g=%h len=%0d done=%0d, required no further run",
                  run_key[14:7], run_key[6:0], run_len, run_done);
      end else begin
         e = q.pop_front();
         if (e.csn != run_key[14:7] || e.ag != run_key[6:0] || e.len != run_len || e.done != run_done) begin
            bad++;
            $display("FAIL run: got csn=%h a_g=%h len=%0d done=%0d, required csn=%h a_g=%h len=%0d done=%0d",
                     run_key[14:7], run_key[6:0], run_len, run_done, e.csn, e.ag, e.len, e.done);
         end
      end
   endtask

   // Sample at the falling edge, well away from the active edge
   always @(negedge clk) begin
      if (!mon_on) begin
         run_act = 1'b0;
      end else if (!run_act) begin
         run_act  = 1'b1;
         run_key  = {num_csn, num_a_g};
         run_len  = 1;
         run_done = int'(frame_done);
      end else if ({num_csn, num_a_g} == run_key) begin
         run_len  = run_len + 1;
         run_done = run_done + int'(frame_done);
      end else begin
         check_run();
         run_key  = {num_csn, num_a_g};
         run_len  = 1;
         run_done = int'(frame_done);
      end
   end

   // ---------------- stimulus ----------------
   task automatic to_cycle(input int k);
      while (cur < k) begin
         @(posedge clk);
         cur++;
      end
      #1;
   endtask

   task automatic write_at(input int k, input logic [31:0] v);
      to_cycle(k);
      wr_en   = 1'b1;
      wr_data = v;
      to_cycle(k + 1);
      wr_en   = 1'b0;
   endtask

   task automatic check_val(input string name, input logic [14:0] got, input logic [14:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   initial begin
      int budget;
      resetn  = 1'b0;
      en      = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_csn", {7'h0, num_csn}, {7'h0, 8'hFF});
      check_val("reset_a_g", {8'h0, num_a_g}, {8'h0, 7'h00});
      check_val("reset_frame_done", {14'h0, frame_done}, 15'h0);

      // Release just after an edge: this interval is cycle 0
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cur    = 0;
      mon_on = 1'b1;
      add_frame(32'h0, 0);

      // Write during digit 3 of frame 0: visible from frame 1
      write_at(21, 32'h89ABCDEF);
      add_frame(32'h89ABCDEF, 1);

      // Write on the last dwell cycle of frame 1: bypasses into frame 2
      write_at(95, 32'h00000005);
      add_frame(32'h00000005, 1);

      // Two writes in frame 2: last one wins in frame 3
      write_at(100, 32'h11111111);
      write_at(110, 32'h22222222);
      add_frame(32'h22222222, 1);

      write_at(150, 32'h00000120);
      add_frame(32'h00000120, 1);

      // Frame 5: disable mid-digit 3, then resume with a fresh frame
      to_cycle(200);
      add_blank(2, 1);
      add_slot(32'h120, 0, 4, 0);
      add_blank(2, 0);
      add_slot(32'h120, 1, 4, 0);
      add_blank(2, 0);
      add_slot(32'h120, 2, 4, 0);
      add_blank(2, 0);
      add_slot(32'h120, 3, 2, 0);
      add_blank(11, 0);
      add_slot(32'h120, 0, 4, 0);
      for (int d = 1; d < 8; d++) begin
         add_blank(2, 0);
         add_slot(32'h120, d, 4, 0);
      end
      add_blank(2, 1);
      flush_runs();

      to_cycle(261);
      en = 1'b0;
      to_cycle(271);
      en = 1'b1;

      budget = 200;
      while (q.size() != 0 && budget > 0) begin
         @(posedge clk);
         cur++;
         budget--;
      end
      #1;
      mon_on = 1'b0;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d runs outstanding, required 0", q.size());
      end

      // Asynchronous reset in the middle of digit 0 of the following frame
      to_cycle(323);
      check_val("pre_reset_digit0", {num_csn, num_a_g}, {8'hFE, 7'h7E});
      #2;
      resetn = 1'b0;
      #1;
      check_val("async_reset_csn", {7'h0, num_csn}, {7'h0, 8'hFF});
      check_val("async_reset_a_g", {8'h0, num_a_g}, {8'h0, 7'h00});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound on simulation time
   initial begin
      #100000;
      $display("FAIL timeout: got no completion, required finish before 100000 time units");
      $fatal(1);
   end

endmodule
